// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: one outstanding memory read at a time fills a DEPTH-entry {pc,inst}
// FIFO, which drains into a registered decode-side output stage with jump/stall/flush control.
module fetch_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_stall,
    input  logic                       i_flush,
    input  logic                       i_jump,
    input  logic [XLEN-1:0]            i_jump_addr,
    input  logic [31:0]                i_inst_data,
    input  logic                       i_inst_ack,
    output logic                       o_inst_req,
    output logic [XLEN-1:0]            or_inst_req_addr,
    output logic [31:0]                or_inst_data,
    output logic [XLEN-1:0]            or_pc,
    output logic                       o_valid,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              LW      = $clog2(DEPTH + 1);
    localparam logic [LW-1:0]   FULL    = LW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [XLEN-1:0] fifo_pc_q   [DEPTH];
    logic [31:0]     fifo_inst_q [DEPTH];
    logic [31:0]     inst_q;
    logic [XLEN-1:0] out_pc_q;
    logic            valid_q;
    logic            push, pop;

    // A jump always discards the returning word; stall and flush keep the head in place.
    assign push = (state_q == S_REQ) && i_inst_ack && !i_jump;
    assign pop  = !i_jump && !i_stall && !i_flush && (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (i_jump)
            level_d = '0;
        else if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_jump) begin
                    pc_d       = i_jump_addr;
                    req_addr_d = i_jump_addr;
                    state_d    = S_REQ;
                end else if (level_q < FULL) begin
                    req_addr_d = pc_q;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (i_jump) begin
                    pc_d = i_jump_addr;
                    if (i_inst_ack) begin
                        req_addr_d = i_jump_addr;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (i_inst_ack) begin
                    pc_d = pc_q + PC_STEP;
                    if (level_d < FULL)
                        req_addr_d = pc_q + PC_STEP;
                    else
                        state_d = S_IDLE;
                end
            end
            S_DROP: begin
                // The stale request stays on the bus at its old address until memory answers.
                if (i_jump)
                    pc_d = i_jump_addr;
                if (i_inst_ack) begin
                    req_addr_d = pc_d;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            level_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inst_q     <= '0;
            out_pc_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            level_q    <= level_d;
            if (i_jump) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (i_jump) begin
                inst_q  <= NOP;
                valid_q <= 1'b0;
            end else if (i_stall) begin
                inst_q  <= inst_q;
            end else if (i_flush) begin
                inst_q  <= NOP;
                valid_q <= 1'b1;
            end else if (pop) begin
                inst_q   <= fifo_inst_q[rd_ptr_q];
                out_pc_q <= fifo_pc_q[rd_ptr_q];
                valid_q  <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= pc_q;
            fifo_inst_q[wr_ptr_q] <= i_inst_data;
        end
    end

    assign o_inst_req       = (state_q != S_IDLE);
    assign o_busy           = (state_q != S_IDLE);
    assign or_inst_req_addr = req_addr_q;
    assign or_inst_data     = inst_q;
    assign or_pc            = out_pc_q;
    assign o_valid          = valid_q;
    assign o_level          = level_q;
endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: width of all addresses and PCs.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of prefetch buffer entries, power of two, at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 The block SHALL have parameter NOP, default 32'h00000013: instruction word inserted on flush.
REQ-005 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-006 Port i_clk, input, 1: CPU clock; all state SHALL change only on its rising edge.
REQ-007 Port i_rst, input, 1: synchronous active-high reset.
REQ-008 Port i_stall, input, 1: decode not ready; the output register holds.
REQ-009 Port i_flush, input, 1: replace the next output with NOP.
REQ-010 Port i_jump, input, 1: redirect fetch.
REQ-011 Port i_jump_addr, input, XLEN: redirect target.
REQ-012 Port i_inst_data, input, 32: memory read data.
REQ-013 Port i_inst_ack, input, 1: memory read data valid for the current request.
REQ-014 Port o_inst_req, output, 1: memory read request, level-held until acknowledged.
REQ-015 Port or_inst_req_addr, output, XLEN: memory request address.
REQ-016 Port or_inst_data, output, 32: instruction to decode.
REQ-017 Port or_pc, output, XLEN: PC of or_inst_data.
REQ-018 Port o_valid, output, 1: or_inst_data/or_pc are valid this cycle.
REQ-019 Port o_busy, output, 1: memory request outstanding (drives the off-board memory stall).
REQ-020 Port o_level, output, clog2(DEPTH+1): current buffer occupancy.

Function
REQ-021 The block SHALL hold a fetch PC, a FIFO of DEPTH {pc,inst} entries and a request FSM with states IDLE, REQ and DROP.
REQ-022 In IDLE, the FSM SHALL go to REQ when the registered occupancy is below DEPTH; otherwise it SHALL stay in IDLE.
REQ-023 In REQ, o_inst_req SHALL be 1 and or_inst_req_addr SHALL equal the fetch PC, both held stable until i_inst_ack.
REQ-024 On REQ and i_inst_ack with no jump, the block SHALL push {fetch PC, i_inst_data} and set fetch PC to fetch PC+4, wrapping modulo 2^XLEN.
REQ-025 After such a push, the FSM SHALL stay in REQ if the post-push occupancy is below DEPTH, else go to IDLE; a simultaneous pop SHALL count when computing that occupancy.
REQ-026 On i_jump, the block SHALL clear the FIFO and load fetch PC with i_jump_addr.
REQ-027 On i_jump in REQ without ack, the FSM SHALL go to DROP.
REQ-028 On i_jump in REQ with ack, the block SHALL discard the data and the FSM SHALL go to REQ.
REQ-029 On i_jump in IDLE, the FSM SHALL go to REQ.
REQ-030 In DROP, o_inst_req SHALL stay 1 with the old address until i_inst_ack; the data SHALL be discarded and the FSM SHALL go to REQ at the new fetch PC.
REQ-031 A further i_jump while in DROP SHALL update only the fetch PC.
REQ-032 o_busy SHALL be 1 exactly when the FSM is in REQ or DROP.
REQ-033 Output register priority SHALL be i_rst > i_jump > i_stall > i_flush > normal.
REQ-034 On i_jump, o_valid SHALL become 0 and or_inst_data SHALL become NOP.
REQ-035 On i_stall, all output registers SHALL hold and the FIFO SHALL not pop.
REQ-036 On i_flush without stall, or_inst_data SHALL become NOP, or_pc SHALL hold, o_valid SHALL become 1, and the FIFO SHALL not pop.
REQ-037 In the normal case with the FIFO non-empty, the block SHALL pop the head into or_inst_data/or_pc and set o_valid to 1.
REQ-038 In the normal case with the FIFO empty, o_valid SHALL become 0 and the data outputs SHALL hold.
REQ-039 Latency SHALL be: ack accepted at edge M, output visible after edge M+1 when not stalled; there is no FIFO bypass.
REQ-040 Push and pop in the same cycle SHALL leave occupancy unchanged; the FIFO SHALL never overflow or underflow.

Reset
REQ-041 While i_rst is high at a clock edge, fetch PC SHALL become RESET_PC, the FIFO SHALL clear, the FSM SHALL go to IDLE, o_inst_req/o_valid/o_busy/o_level SHALL become 0, and or_inst_data/or_pc/or_inst_req_addr SHALL become 0.
REQ-042 A reset asserted mid-request SHALL abandon that request, and any later ack SHALL be ignored.

Verification
REQ-043 Reset, then memory acks each request one cycle after it rises with data=addr -> or_pc sequence 0,4,8,C with matching or_inst_data, o_valid continuous after fill.
REQ-044 i_stall held 10 cycles, DEPTH=4 -> o_level saturates at 4, o_inst_req drops, outputs held, no lost or duplicated PCs after release.
REQ-045 i_jump to 0x100 while a request to 0x8 is unacked, ack arrives 3 cycles later -> that data is discarded, next request addr 0x100, first valid output or_pc=0x100.
REQ-046 i_jump coincident with ack -> the acked data is never output, the FIFO is empty next cycle, and the next request addr equals i_jump_addr.
REQ-047 i_flush one cycle with head pc 0x10 -> output 0x00000013 with o_valid=1, then pc 0x10 on the following cycle.
REQ-048 Fetch PC at 0xFFFFFFFC, ack -> next request addr 0x00000000.
